// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: ALU op codes, RV32I opcode/funct fields,
// branch classes and the issue FSM state encoding. The ALU uses the same op codes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_OR  = 4'h2,
    ALU_SLL = 4'h3,
    ALU_SRL = 4'h4,
    ALU_LUI = 4'h5,
    ALU_AND = 4'h6,
    ALU_XOR = 4'h7,
    ALU_BEQ = 4'h8,
    ALU_BNE = 4'h9,
    ALU_BLT = 4'hA,
    ALU_BGE = 4'hB,
    ALU_JAL = 4'hC,
    ALU_SW  = 4'hD
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } issue_state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2
  } br_kind_e;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / ALU / result handshake bundle for alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic        branch_taken_o;

  modport master (
    output instr_valid_i, instr_i, rs1_data_i, rs2_data_i,
    output alu_result_i, alu_zero_i, res_ready_i,
    input  instr_ready_o, alu_op_o, alu_a_o, alu_b_o,
    input  res_valid_o, res_data_o, branch_taken_o
  );

  modport slave (
    input  instr_valid_i, instr_i, rs1_data_i, rs2_data_i,
    input  alu_result_i, alu_zero_i, res_ready_i,
    output instr_ready_o, alu_op_o, alu_a_o, alu_b_o,
    output res_valid_o, res_data_o, branch_taken_o
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: ALU op, operand selection/immediates and branch class.
// Optional illegal flag output when ALU_ISSUE_ILLEGAL_EN is defined.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output alu_op_e     op_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output br_kind_e    br_o
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        illegal_o
`endif
);

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] i_imm_s;
  logic [31:0] s_imm_s;
  logic [31:0] shamt_s;
  logic        ill_s;
  alu_op_e     op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  br_kind_e    br_s;

  assign opcode_s = instr_i[6:0];
  assign f3_s     = instr_i[14:12];
  assign f7_s     = instr_i[31:25];
  assign i_imm_s  = sext12(instr_i[31:20]);
  assign s_imm_s  = sext12({instr_i[31:25], instr_i[11:7]});
  assign shamt_s  = {27'd0, instr_i[24:20]};

  // Opcode/funct decode with operand selection; unknown encodings collapse to ADD 0,0
  always_comb begin
    op_s  = ALU_ADD;
    a_s   = 32'h0000_0000;
    b_s   = 32'h0000_0000;
    br_s  = BR_NONE;
    ill_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        a_s = rs1_data_i;
        b_s = rs2_data_i;
        case (f3_s)
          F3_ADD_SUB: begin
            if (f7_s == F7_BASE) begin
              op_s = ALU_ADD;
            end else if (f7_s == F7_ALT) begin
              op_s = ALU_SUB;
            end else begin
              ill_s = 1'b1;
            end
          end
          F3_SLL: op_s = ALU_SLL;
          F3_SRL: begin
            if (f7_s == F7_BASE) begin
              op_s = ALU_SRL;
            end else begin
              ill_s = 1'b1;
            end
          end
          F3_XOR: op_s = ALU_XOR;
          F3_OR:  op_s = ALU_OR;
          F3_AND: op_s = ALU_AND;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        a_s = rs1_data_i;
        b_s = i_imm_s;
        case (f3_s)
          F3_ADD_SUB: op_s = ALU_ADD;
          F3_XOR:     op_s = ALU_XOR;
          F3_OR:      op_s = ALU_OR;
          F3_AND:     op_s = ALU_AND;
          F3_SLL, F3_SRL: begin
            b_s  = shamt_s;
            op_s = (f3_s == F3_SLL) ? ALU_SLL : ALU_SRL;
            if (f7_s != F7_BASE) begin
              ill_s = 1'b1;
            end else begin
              ill_s = 1'b0;
            end
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        a_s   = rs1_data_i;
        b_s   = i_imm_s;
        ill_s = (f3_s != F3_WORD);
      end
      OPC_JALR: begin
        a_s   = rs1_data_i;
        b_s   = i_imm_s;
        ill_s = (f3_s != F3_JALR);
      end
      OPC_STORE: begin
        op_s  = ALU_SW;
        a_s   = rs1_data_i;
        b_s   = s_imm_s;
        ill_s = (f3_s != F3_WORD);
      end
      OPC_LUI: begin
        op_s = ALU_LUI;
        b_s  = {12'd0, instr_i[31:12]};
      end
      OPC_BRANCH: begin
        a_s  = rs1_data_i;
        b_s  = rs2_data_i;
        br_s = BR_COND;
        case (f3_s)
          F3_BEQ:  op_s = ALU_BEQ;
          F3_BNE:  op_s = ALU_BNE;
          F3_BLT:  op_s = ALU_BLT;
          F3_BGE:  op_s = ALU_BGE;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_JAL: begin
        op_s = ALU_JAL;
        br_s = BR_JAL;
      end
      default: ill_s = 1'b1;
    endcase
    if (ill_s) begin
      op_s = ALU_ADD;
      a_s  = 32'h0000_0000;
      b_s  = 32'h0000_0000;
      br_s = BR_NONE;
    end else begin
      op_s = op_s;
    end
  end

  assign op_o = op_s;
  assign a_o  = a_s;
  assign b_o  = b_s;
  assign br_o = br_s;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal_o = ill_s;
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-instruction ALU issue controller: IDLE -> ISSUE -> DONE handshake around an external ALU.
// Define ALU_ISSUE_ILLEGAL_EN to add the illegal_o output flagging undecodable instructions.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic             illegal_o
`endif
);

  issue_state_e state_r;
  issue_state_e state_s;
  logic         accept_s;

  alu_op_e      dec_op_s;
  logic [31:0]  dec_a_s;
  logic [31:0]  dec_b_s;
  br_kind_e     dec_br_s;

  alu_op_e      op_r;
  logic [31:0]  a_r;
  logic [31:0]  b_r;
  br_kind_e     br_r;
  logic [31:0]  res_data_r;
  logic         taken_r;
  logic         res_valid_r;
  logic         ready_r;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic         dec_ill_s;
  logic         ill_pend_r;
  logic         illegal_r;
`endif

  alu_issue_decode u_decode (
    .instr_i    (bus.instr_i),
    .rs1_data_i (bus.rs1_data_i),
    .rs2_data_i (bus.rs2_data_i),
    .op_o       (dec_op_s),
    .a_o        (dec_a_s),
    .b_o        (dec_b_s),
    .br_o       (dec_br_s)
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    .illegal_o  (dec_ill_s)
`endif
  );

  // Next-state logic; accept only from IDLE
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.instr_valid_i) begin
          accept_s = 1'b1;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_DONE;
      ST_DONE: begin
        if (bus.res_ready_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on accept, result/branch capture in ISSUE, result handshake in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r        <= ALU_ADD;
      a_r         <= 32'h0000_0000;
      b_r         <= 32'h0000_0000;
      br_r        <= BR_NONE;
      res_data_r  <= 32'h0000_0000;
      taken_r     <= 1'b0;
      res_valid_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      ready_r <= (state_s == ST_IDLE);
      if (accept_s) begin
        op_r <= dec_op_s;
        a_r  <= dec_a_s;
        b_r  <= dec_b_s;
        br_r <= dec_br_s;
      end
      if (state_r == ST_ISSUE) begin
        res_data_r  <= bus.alu_result_i;
        taken_r     <= (br_r == BR_JAL) || ((br_r == BR_COND) && !bus.alu_zero_i);
        res_valid_r <= 1'b1;
      end else if ((state_r == ST_DONE) && bus.res_ready_i) begin
        res_valid_r <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  // Illegal flag follows the same timing as res_valid_o
  always_ff @(posedge clk) begin
    if (reset) begin
      ill_pend_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        ill_pend_r <= dec_ill_s;
      end
      if (state_r == ST_ISSUE) begin
        illegal_r <= ill_pend_r;
      end else if ((state_r == ST_DONE) && bus.res_ready_i) begin
        illegal_r <= 1'b0;
      end
    end
  end

  assign illegal_o = illegal_r;
`endif

  assign bus.instr_ready_o  = ready_r;
  assign bus.alu_op_o       = op_r;
  assign bus.alu_a_o        = a_r;
  assign bus.alu_b_o        = b_r;
  assign bus.res_valid_o    = res_valid_r;
  assign bus.res_data_o     = res_data_r;
  assign bus.branch_taken_o = taken_r;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: instr_valid_i  input  1  instruction/operands offered.
REQ-004 SHALL have port: instr_ready_o  output  1  block can accept an instruction.
REQ-005 SHALL have port: instr_i  input  32  RV32I instruction word.
REQ-006 SHALL have port: rs1_data_i, rs2_data_i  input  32 each  register operands, sampled with instr_i.
REQ-007 SHALL have port: alu_op_o  output  4  ALU operation code to the ALU.
REQ-008 SHALL have port: alu_a_o, alu_b_o  output  32 each  ALU operands.
REQ-009 SHALL have port: alu_result_i  input  32  ALU result, combinational from alu_* outputs.
REQ-010 SHALL have port: alu_zero_i  input  1  ALU zero flag.
REQ-011 SHALL have port: res_valid_o  output  1  result available.
REQ-012 SHALL have port: res_ready_i  input  1  consumer accepts the result.
REQ-013 SHALL have port: res_data_o  output  32  captured ALU result.
REQ-014 SHALL have port: branch_taken_o  output  1  branch/jump resolves taken; valid with res_valid_o.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE; instr_ready_o=1 only in IDLE.
REQ-016 SHALL, in IDLE on instr_valid_i&instr_ready_o, register decoded op and operands, then enter ISSUE.
REQ-017 SHALL, at end of the single ISSUE cycle, capture alu_result_i into res_data_o and !alu_zero_i into the branch flag, then enter DONE.
REQ-018 SHALL hold res_valid_o=1 in DONE, with res_data_o/branch_taken_o stable until res_ready_i=1, then return to IDLE; a new instruction is not accepted in that cycle.
REQ-019 SHALL drive alu_op_o/alu_a_o/alu_b_o from registers only, stable from ISSUE through DONE.
REQ-020 SHALL use op codes ADD=0 SUB=1 OR=2 SLL=3 SRL=4 LUI=5 AND=6 XOR=7 BEQ=8 BNE=9 BLT=A BGE=B JAL=C SW=D.
REQ-021 SHALL decode opcode 0110011 (A=rs1,B=rs2): f3 000 ADD (f7 0000000) / SUB (f7 0100000); 001 SLL; 101 SRL (f7 0); 100 XOR; 110 OR; 111 AND.
REQ-022 SHALL decode 0010011 (A=rs1,B=sign-extended imm[31:20]): 000 ADD, 100 XOR, 110 OR, 111 AND; 001 SLL / 101 SRL with f7 0 and B=shamt zero-extended.
REQ-023 SHALL decode lw (0000011,f3 010) and jalr (1100111,f3 000) as ADD with A=rs1, B=I-immediate.
REQ-024 SHALL decode sw (0100011,f3 010) as SW, A=rs1, B=sign-extended S-immediate {imm[31:25],imm[11:7]}.
REQ-025 SHALL decode lui (0110111) as LUI, A=0, B=instr_i[31:12] zero-extended.
REQ-026 SHALL decode 1100011 as BEQ/BNE/BLT/BGE for f3 000/001/100/101, A=rs1, B=rs2; branch_taken_o = !alu_zero_i captured in ISSUE.
REQ-027 SHALL decode jal (1101111) as JAL, A=B=0, branch_taken_o=1 regardless of ALU.
REQ-028 SHALL force branch_taken_o=0 for all non-branch, non-jal instructions.
REQ-029 SHALL decode any other encoding as ADD with A=B=0 (result 0).

Reset
REQ-030 SHALL on reset enter IDLE and clear alu_op_o, alu_a_o, alu_b_o, res_data_o, branch_taken_o, res_valid_o to 0; instr_ready_o=1 in cycle after reset.
REQ-031 SHALL on reset in ISSUE or DONE discard the in-flight instruction; no res_valid_o pulse follows.
REQ-032 SHALL ignore instr_valid_i while reset=1.

Configuration
REQ-033 SHALL, with ALU_ISSUE_ILLEGAL_EN defined, provide output illegal_o (1 bit), set with res_valid_o for REQ-029 encodings, reset 0, cleared on return to IDLE.
REQ-034 SHALL, without ALU_ISSUE_ILLEGAL_EN, omit illegal_o; REQ-029 behaviour unchanged.

Structure
REQ-035 SHALL place ALU op-code constants, RV32I opcode/funct3/funct7 constants and FSM state encoding in shared package alu_pkg, reused by the ALU.
REQ-036 SHALL isolate decode/immediate generation in combinational sub-module alu_issue_decode; FSM and registers stay in alu_issue_ctrl.

Verification
REQ-037 SHALL test add x,rs1=5,rs2=7 (0x00208033 form) -> alu_op_o=0, res_data_o=12, res_valid_o two cycles after accept, branch_taken_o=0.
REQ-038 SHALL test addi imm=-1 with rs1=0x10 -> alu_b_o=0xFFFFFFFF, res_data_o=0x0F.
REQ-039 SHALL test beq rs1=rs2=3 -> op 8, branch_taken_o=1; bne same operands -> branch_taken_o=0.
REQ-040 SHALL test res_ready_i held 0 for 5 cycles -> res_valid_o/res_data_o stable, instr_ready_o=0, new instr_valid_i ignored.
REQ-041 SHALL test reset asserted in ISSUE -> next cycle IDLE, all outputs 0, no result emitted.
REQ-042 SHALL test instr_i=0xFFFFFFFF -> res_data_o=0; illegal_o=1 only when ALU_ISSUE_ILLEGAL_EN defined.
